// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: checks conditional branches in EX against the
// BTFNT guess made at fetch, squashes wrong-path work in its own pipeline
// copy, and keeps saturating branch/mispredict statistics.
module branch_resolution_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halted,
  input  logic             fetch_valid,
  input  logic [4:0]       opcode,
  input  logic [16:0]      branch_target,
  input  logic             cond_EX,
  input  logic             stats_clear,
  output logic             guess_wrong,
  output logic             squash_ID,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [4:0] OP_BT = 5'd23;
  localparam logic [4:0] OP_BF = 5'd24;

  logic advance;
  logic is_cond;
  logic pred_taken;
  logic is_bt;
  logic actual_taken;

  // Only the sign bit of the offset matters for the BTFNT guess.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[15:0];

  logic valid_id_q, is_cond_id_q, pred_id_q, bt_id_q;
  logic valid_ex_q, is_cond_ex_q, pred_ex_q, bt_ex_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // IF decode: backward conditional branches are guessed taken.
  always_comb begin
    advance    = !(stall | halted);
    is_cond    = (opcode == OP_BT) || (opcode == OP_BF);
    is_bt      = (opcode == OP_BT);
    pred_taken = is_cond & branch_target[16];
  end

  // EX resolution; suppressed while held so a stalled branch pulses once on release.
  always_comb begin
    actual_taken = bt_ex_q ? cond_EX : !cond_EX;
    guess_wrong  = valid_ex_q & is_cond_ex_q & (pred_ex_q != actual_taken) & advance;
    squash_ID    = guess_wrong;
  end

  // IF->ID->EX prediction pipeline; a mispredict kills the two younger entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_id_q   <= 1'b0;
      is_cond_id_q <= 1'b0;
      pred_id_q    <= 1'b0;
      bt_id_q      <= 1'b0;
      valid_ex_q   <= 1'b0;
      is_cond_ex_q <= 1'b0;
      pred_ex_q    <= 1'b0;
      bt_ex_q      <= 1'b0;
    end else if (advance) begin
      valid_id_q   <= fetch_valid & !guess_wrong;
      is_cond_id_q <= is_cond;
      pred_id_q    <= pred_taken;
      bt_id_q      <= is_bt;
      valid_ex_q   <= valid_id_q & !guess_wrong;
      is_cond_ex_q <= is_cond_id_q;
      pred_ex_q    <= pred_id_q;
      bt_ex_q      <= bt_id_q;
    end
  end

  // Next counter values: clear wins, otherwise saturating increment on advance.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (stats_clear) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (advance) begin
      if (valid_ex_q && is_cond_ex_q && !(&branch_cnt_q))
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (guess_wrong && !(&mispred_cnt_q))
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit: a spec-level pipeline model
// pushes expected outputs into queues that are popped when the DUT responds.
module tb_branch_resolution_unit;

  localparam logic [4:0] BT  = 5'd23;
  localparam logic [4:0] BF  = 5'd24;
  localparam logic [4:0] JAL = 5'd25;
  localparam int SMALL_W = 3;
  localparam int MAX16 = 65535;
  localparam int MAX3  = 7;

  logic clk = 1'b0;
  logic rst_n, stall, halted, fetch_valid, cond_EX, stats_clear;
  logic [4:0]  opcode;
  logic [16:0] branch_target;
  logic        guess_wrong, squash_ID, gw_s, sq_s;
  logic [15:0] branch_count, mispredict_count;
  logic [SMALL_W-1:0] bc_s, mc_s;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int bc;
    int mc;
    int bc3;
    int mc3;
  } cnt_t;

  logic q_gw[$];
  cnt_t q_cnt[$];

  // Model state
  logic m_v_id = 0, m_c_id = 0, m_p_id = 0, m_b_id = 0;
  logic m_v_ex = 0, m_c_ex = 0, m_p_ex = 0, m_b_ex = 0;
  cnt_t m_cnt = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  branch_resolution_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halted(halted),
    .fetch_valid(fetch_valid), .opcode(opcode), .branch_target(branch_target),
    .cond_EX(cond_EX), .stats_clear(stats_clear), .guess_wrong(guess_wrong),
    .squash_ID(squash_ID), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_resolution_unit #(.CNT_W(SMALL_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halted(halted),
    .fetch_valid(fetch_valid), .opcode(opcode), .branch_target(branch_target),
    .cond_EX(cond_EX), .stats_clear(stats_clear), .guess_wrong(gw_s),
    .squash_ID(sq_s), .branch_count(bc_s), .mispredict_count(mc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    m_v_id = 0; m_c_id = 0; m_p_id = 0; m_b_id = 0;
    m_v_ex = 0; m_c_ex = 0; m_p_ex = 0; m_b_ex = 0;
    m_cnt = '{0, 0, 0, 0};
    q_gw.delete();
    q_cnt.delete();
  endtask

  // One clock cycle: drive, predict, check outputs before and after the edge.
  task automatic step(input logic fv, input logic [4:0] op, input logic [16:0] tgt,
                      input logic cnd, input logic st, input logic hl, input logic clr);
    logic adv, act, exp_gw, got_gw, n_cond;
    cnt_t e;
    @(negedge clk);
    fetch_valid = fv; opcode = op; branch_target = tgt;
    cond_EX = cnd; stall = st; halted = hl; stats_clear = clr;
    #1;
    adv    = !(st | hl);
    act    = m_b_ex ? cnd : !cnd;
    exp_gw = m_v_ex & m_c_ex & (m_p_ex != act) & adv;
    q_gw.push_back(exp_gw);
    if (clr) begin
      m_cnt = '{0, 0, 0, 0};
    end else if (adv) begin
      if (m_v_ex & m_c_ex) begin
        m_cnt.bc  = sat_inc(m_cnt.bc, MAX16);
        m_cnt.bc3 = sat_inc(m_cnt.bc3, MAX3);
      end
      if (exp_gw) begin
        m_cnt.mc  = sat_inc(m_cnt.mc, MAX16);
        m_cnt.mc3 = sat_inc(m_cnt.mc3, MAX3);
      end
    end
    q_cnt.push_back(m_cnt);
    got_gw = q_gw.pop_front();
    chk("guess_wrong", 32'(guess_wrong), 32'(got_gw));
    chk("squash_ID", 32'(squash_ID), 32'(got_gw));
    chk("guess_wrong_small", 32'(gw_s), 32'(got_gw));
    if (adv) begin
      n_cond = (op == BT) || (op == BF);
      m_v_ex = m_v_id & !exp_gw;
      m_c_ex = m_c_id; m_p_ex = m_p_id; m_b_ex = m_b_id;
      m_v_id = fv & !exp_gw;
      m_c_id = n_cond;
      m_p_id = n_cond & tgt[16];
      m_b_id = (op == BT);
    end
    @(posedge clk);
    #1;
    e = q_cnt.pop_front();
    chk("branch_count", 32'(branch_count), 32'(e.bc));
    chk("mispredict_count", 32'(mispredict_count), 32'(e.mc));
    chk("branch_count_small", 32'(bc_s), 32'(e.bc3));
    chk("mispredict_count_small", 32'(mc_s), 32'(e.mc3));
  endtask

  task automatic idle(input logic cnd);
    step(1'b0, 5'd0, 17'd0, cnd, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; halted = 1'b0; fetch_valid = 1'b0;
    opcode = 5'd0; branch_target = 17'd0; cond_EX = 1'b0; stats_clear = 1'b0;
    #3;
    chk("reset_guess_wrong", 32'(guess_wrong), 32'd0);
    chk("reset_squash_ID", 32'(squash_ID), 32'd0);
    chk("reset_branch_count", 32'(branch_count), 32'd0);
    chk("reset_mispredict_count", 32'(mispredict_count), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Forward BT, resolves not taken: correct guess.
    step(1'b1, BT, 17'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("fwd_bt_branch_count", 32'(branch_count), 32'd1);
    chk("fwd_bt_mispredict_count", 32'(mispredict_count), 32'd0);

    // Backward BF guessed taken but not taken; younger backward BT is squashed.
    step(1'b1, BF, 17'h1FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, BT, 17'h1FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("bf_branch_count", 32'(branch_count), 32'd2);
    chk("bf_mispredict_count", 32'(mispredict_count), 32'd1);

    // Mispredicting BT held in EX by stall/halt, pulses once on release.
    step(1'b1, BT, 17'h1FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("stall_branch_count", 32'(branch_count), 32'd3);
    chk("stall_mispredict_count", 32'(mispredict_count), 32'd2);

    // JAL backward: never counted, never mispredicted.
    step(1'b1, JAL, 17'h1FFF8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("jal_branch_count", 32'(branch_count), 32'd3);

    // Drive the narrow instance into saturation.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, BT, 17'h1FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
    end
    chk("sat_branch_count_small", 32'(bc_s), 32'd7);
    chk("sat_mispredict_count_small", 32'(mc_s), 32'd7);
    chk("sat_mispredict_count", 32'(mispredict_count), 32'd8);

    // Clear coinciding with a branch in EX.
    step(1'b1, BT, 17'h1FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_branch_count", 32'(branch_count), 32'd0);
    chk("clear_mispredict_count_small", 32'(mc_s), 32'd0);

    // Clear while stalled.
    step(1'b1, BF, 17'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 5'd0, 17'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while a mispredict sits in EX.
    step(1'b1, BT, 17'h1FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    fetch_valid = 1'b0; opcode = 5'd0; cond_EX = 1'b0;
    stall = 1'b0; halted = 1'b0; stats_clear = 1'b0;
    #1;
    chk("pre_reset_guess_wrong", 32'(guess_wrong), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_guess_wrong", 32'(guess_wrong), 32'd0);
    chk("async_squash_ID", 32'(squash_ID), 32'd0);
    chk("async_branch_count", 32'(branch_count), 32'd0);
    chk("async_mispredict_count", 32'(mispredict_count), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolution_unit.md
# branch_resolution_unit

Resolves conditional branches in EX against the BTFNT (backward-taken, forward-not-taken) guess made at fetch. It tracks each fetched instruction's prediction through IF→ID→EX and raises `guess_wrong` when the actual outcome differs, which triggers recovery with the stored not-predicted offset. It squashes wrong-path entries in its own pipeline copy and keeps saturating branch and mispredict statistics for the debug/ECALL path.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `stall`  in  1  pipeline stall; holds all stage registers.
- `halted`  in  1  core halted; same hold behaviour as `stall`.
- `fetch_valid`  in  1  the IF-stage instruction is real, not a bubble.
- `opcode`  in  5  IF-stage opcode, using the same encoding the predictor uses (`BT`=23, `BF`=24, `JAL`=25).
- `branch_target`  in  17  IF-stage signed branch offset.
- `cond_EX`  in  1  ALU condition result for the instruction currently in EX.
- `stats_clear`  in  1  synchronous clear of both statistics counters.
- `guess_wrong`  out  1  mispredict detected in EX this cycle (combinational).
- `squash_ID`  out  1  the ID-stage instruction is wrong-path; equal to `guess_wrong`.
- `branch_count`  out  `CNT_W`  number of resolved `BT`/`BF` instructions.
- `mispredict_count`  out  `CNT_W`  number of mispredicts.

## Operation
- **IF decode (combinational).**
  - `is_cond` = opcode is `BT` or `BF`.
  - `pred_taken` = `is_cond` and `branch_target[16]` (negative offset means predicted taken).
  - `is_bt` = opcode is `BT`.
- **Stage registers.**
  - ID holds {`valid_ID`, `is_cond_ID`, `pred_ID`, `bt_ID`}; EX holds the same set with `_EX` suffixes.
  - An advance happens when `!(stall | halted)`. On an advance, IF loads into ID (valid = `fetch_valid`) and ID loads into EX.
  - When `stall | halted`, every stage register holds its value.
- **Resolution in EX.**
  - `actual_taken` = `bt_EX ? cond_EX : !cond_EX`.
  - `guess_wrong` = `valid_EX & is_cond_EX & (pred_EX != actual_taken) & !stall & !halted`.
- **Squash.**
  - On an advancing edge with `guess_wrong` = 1, `valid_EX` is loaded with 0 instead of `valid_ID`, and `valid_ID` is loaded with 0 instead of `fetch_valid`.
  - This discards both wrong-path instructions (the ones in ID and IF at detection time).
  - The fetch in the following cycle is correct-path.
- **JAL / other opcodes.**
  - `JAL` is never mispredicted.
  - Other opcodes, including `JALR`, are not counted and never raise `guess_wrong`.
- **Statistics.** Both counters update on advancing edges only.
  - `branch_count` +1 when `valid_EX & is_cond_EX`.
  - `mispredict_count` +1 when `guess_wrong`.
  - Both saturate at all-ones; there is no wrap.
  - `stats_clear` has priority over increment. A clear coinciding with an increment yields 0.
  - `stats_clear` acts even when stalled or halted.
- **Reset.** While `rst_n` = 0:
  - all valid bits are 0;
  - both counters are 0;
  - `guess_wrong` = `squash_ID` = 0.

## Timing
- **Latency.** A branch fetched in cycle n (no stalls) is in ID at n+1 and in EX at n+2. `guess_wrong` is high during n+2 only.
- **Counter visibility.** Counter updates from cycle n+2 become visible at n+3.
- **One pulse per branch.** `guess_wrong` is a single-cycle pulse per mispredicted branch. If EX is stalled, the output stays 0 until the first non-stalled cycle, then pulses exactly once.
- **Back-to-back branches.** When two mispredicting branches are adjacent, only the older one fires; the younger is squashed.
- **Reset mid-operation.** `rst_n` falling clears state immediately (asynchronous), with no edge needed. The first edge after `rst_n` rises behaves as a normal cycle.
- **Reset priority.** Reset has priority over `stall`, `halted` and `stats_clear`.

## Test plan
- **Forward BT, not taken.** `BT` with target 5, `fetch_valid`=1, then 2 free cycles with `cond_EX`=0.
  - `guess_wrong` stays 0.
  - `branch_count` = 1, `mispredict_count` = 0.
- **Backward BF, mispredicted.** `BF` with target −4 (0x1FFFC), then `cond_EX`=1 (BF not taken).
  - `guess_wrong` = 1 for exactly cycle n+2.
  - A following `BT` fetched at n+1 is squashed and never raises `guess_wrong`.
  - `mispredict_count` = 1.
- **Stall in EX.** Mispredicting `BT` sits in EX with `stall`=1 for 3 cycles.
  - `guess_wrong` = 0 throughout the stall.
  - One pulse on the release cycle.
  - Counters +1 each, once.
- **JAL.** `JAL` with target −8, any `cond_EX`.
  - No `guess_wrong`.
  - `branch_count` unchanged.
- **Saturation and clear.**
  - Preload both counters to 0xFFFE, then resolve 3 mispredicts: both end at 0xFFFF.
  - Then `stats_clear` together with a branch in EX: both counters read 0 the next cycle.
- **Asynchronous reset.** Assert `rst_n`=0 mid-cycle while a mispredict is in EX.
  - `guess_wrong` drops without waiting for an edge.
  - After release, no stale pulse and counters are 0.
